// File: rtl/trng_sampler.sv
// Ring-oscillator entropy consumer: warms up the oscillator, samples it, removes bias
// with a von Neumann corrector, watches for stuck output and packs bits into bytes.
module trng_sampler #(
    parameter int SAMPLE_DIV    = 16,
    parameter int WARMUP_CYCLES = 64,
    parameter int REP_LIMIT     = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       ro_in,
    output logic       ro_activate,
    output logic [7:0] rnd_byte,
    output logic       rnd_valid,
    input  logic       rnd_ready,
    output logic       health_fail,
    output logic       busy
);
    localparam logic [7:0] DIV_LAST  = 8'(SAMPLE_DIV - 1);
    localparam logic [9:0] WARM_LAST = 10'(WARMUP_CYCLES - 1);
    localparam logic [7:0] REP_MAX   = 8'(REP_LIMIT);

    typedef enum logic [2:0] {IDLE, WARMUP, SAMPLE, STALL, FAIL} stateT;

    stateT       r_state;
    logic        r_sync1;
    logic        r_sync2;
    logic [9:0]  r_warmCnt;
    logic [7:0]  r_divCnt;
    logic [7:0]  r_repCnt;
    logic        r_lastSample;
    logic        r_pairValid;
    logic        r_pairBit;
    logic [7:0]  r_shift;
    logic [2:0]  r_bitCnt;
    logic [7:0]  r_held;
    logic [7:0]  r_rndByte;
    logic        r_rndValid;
    logic        r_roActivate;
    logic        r_healthFail;
    logic        r_busy;

    logic        w_sampleTick;
    logic        w_rawBit;
    logic [7:0]  w_repNext;
    logic        w_repTrip;
    logic        w_vnValid;
    logic [7:0]  w_shiftNext;
    logic        w_canLoad;
    logic        w_accept;
    logic        w_stopReq;

    // ro_in is asynchronous to clk; only the second flop is ever observed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= ro_in;
            r_sync2 <= r_sync1;
        end
    end

    assign w_sampleTick = (r_state == SAMPLE) && (r_divCnt == DIV_LAST);
    assign w_rawBit     = r_sync2;
    assign w_repNext    = ((r_repCnt == 8'd0) || (w_rawBit != r_lastSample)) ? 8'd1 : r_repCnt + 8'd1;
    assign w_repTrip    = (w_repNext == REP_MAX);
    assign w_vnValid    = r_pairValid && (w_rawBit != r_pairBit);
    assign w_shiftNext  = {r_shift[6:0], r_pairBit};
    assign w_canLoad    = !r_rndValid || rnd_ready;
    assign w_accept     = r_rndValid && rnd_ready;
    assign w_stopReq    = !enable && ((r_state == WARMUP) || (r_state == SAMPLE) || (r_state == STALL));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_warmCnt    <= 10'd0;
            r_divCnt     <= 8'd0;
            r_repCnt     <= 8'd0;
            r_lastSample <= 1'b0;
            r_pairValid  <= 1'b0;
            r_pairBit    <= 1'b0;
            r_shift      <= 8'd0;
            r_bitCnt     <= 3'd0;
            r_held       <= 8'd0;
            r_rndByte    <= 8'd0;
            r_rndValid   <= 1'b0;
            r_roActivate <= 1'b0;
            r_healthFail <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            // Acceptance clears valid unless a byte loads below in the same cycle.
            if (w_accept) begin
                r_rndValid <= 1'b0;
            end
            if (w_stopReq) begin
                r_state      <= IDLE;
                r_roActivate <= 1'b0;
                r_busy       <= 1'b0;
                r_warmCnt    <= 10'd0;
                r_divCnt     <= 8'd0;
                r_repCnt     <= 8'd0;
                r_lastSample <= 1'b0;
                r_pairValid  <= 1'b0;
                r_pairBit    <= 1'b0;
                r_shift      <= 8'd0;
                r_bitCnt     <= 3'd0;
                r_held       <= 8'd0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (enable) begin
                            r_state      <= WARMUP;
                            r_warmCnt    <= 10'd0;
                            r_roActivate <= 1'b1;
                            r_busy       <= 1'b1;
                        end
                    end
                    WARMUP: begin
                        if (r_warmCnt == WARM_LAST) begin
                            r_state  <= SAMPLE;
                            r_divCnt <= 8'd0;
                        end else begin
                            r_warmCnt <= r_warmCnt + 10'd1;
                        end
                    end
                    SAMPLE: begin
                        r_divCnt <= (r_divCnt == DIV_LAST) ? 8'd0 : r_divCnt + 8'd1;
                        if (w_sampleTick) begin
                            r_lastSample <= w_rawBit;
                            r_repCnt     <= w_repNext;
                            if (w_repTrip) begin
                                r_state      <= FAIL;
                                r_healthFail <= 1'b1;
                                r_roActivate <= 1'b0;
                                r_busy       <= 1'b0;
                                r_pairValid  <= 1'b0;
                                r_pairBit    <= 1'b0;
                                r_shift      <= 8'd0;
                                r_bitCnt     <= 3'd0;
                            end else if (!r_pairValid) begin
                                r_pairValid <= 1'b1;
                                r_pairBit   <= w_rawBit;
                            end else begin
                                r_pairValid <= 1'b0;
                                r_pairBit   <= 1'b0;
                                if (w_vnValid) begin
                                    if (r_bitCnt == 3'd7) begin
                                        r_shift  <= 8'd0;
                                        r_bitCnt <= 3'd0;
                                        if (w_canLoad) begin
                                            r_rndByte  <= w_shiftNext;
                                            r_rndValid <= 1'b1;
                                        end else begin
                                            r_held  <= w_shiftNext;
                                            r_state <= STALL;
                                        end
                                    end else begin
                                        r_shift  <= w_shiftNext;
                                        r_bitCnt <= r_bitCnt + 3'd1;
                                    end
                                end
                            end
                        end
                    end
                    STALL: begin
                        if (rnd_ready) begin
                            r_rndByte  <= r_held;
                            r_rndValid <= 1'b1;
                            r_state    <= SAMPLE;
                        end
                    end
                    FAIL: begin
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign ro_activate = r_roActivate;
    assign rnd_byte    = r_rndByte;
    assign rnd_valid   = r_rndValid;
    assign health_fail = r_healthFail;
    assign busy        = r_busy;

endmodule

// File: tb/tb_trng_sampler.sv
// Directed bench for trng_sampler built with SAMPLE_DIV=4, WARMUP_CYCLES=8, REP_LIMIT=16.
module tb_trng_sampler;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic       ro_in = 1'b0;
    logic       rnd_ready = 1'b0;
    logic       ro_activate;
    logic [7:0] rnd_byte;
    logic       rnd_valid;
    logic       health_fail;
    logic       busy;

    int total = 0;
    int bad = 0;
    int validHigh = 0;

    trng_sampler #(
        .SAMPLE_DIV(4),
        .WARMUP_CYCLES(8),
        .REP_LIMIT(16)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .enable(enable),
        .ro_in(ro_in),
        .ro_activate(ro_activate),
        .rnd_byte(rnd_byte),
        .rnd_valid(rnd_valid),
        .rnd_ready(rnd_ready),
        .health_fail(health_fail),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        rst_n = 1'b0;
        enable = 1'b0;
        ro_in = 1'b0;
        rnd_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Enable is seen at the next rising edge; return on the falling edge after warmup ends,
    // so the next four-clock window ends on the first sampling edge.
    task automatic start_run();
        enable = 1'b1;
        repeat (9) @(negedge clk);
    endtask

    task automatic drive_sample(input logic b);
        ro_in = b;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (rnd_valid === 1'b1) validHigh++;
        end
    endtask

    task automatic drive_pair(input logic first, input logic second);
        drive_sample(first);
        drive_sample(second);
    endtask

    task automatic drive_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) drive_pair(1'b1, 1'b0);
            else      drive_pair(1'b0, 1'b1);
        end
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({ro_activate, rnd_byte, rnd_valid, health_fail, busy} !== 12'h000) begin
            bad++;
            $display("[TB] FAIL reset_outputs: got act=%b byte=%h valid=%b hf=%b busy=%b want all 0",
                     ro_activate, rnd_byte, rnd_valid, health_fail, busy);
        end
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            total++;
            if ({ro_activate, busy} !== 2'b00) begin
                bad++;
                $display("[TB] FAIL idle_quiet cycle %0d: got act=%b busy=%b want 0 0", i, ro_activate, busy);
            end
        end
    endtask

    task automatic test_warmup();
        do_reset();
        enable = 1'b1;
        total++;
        if (ro_activate !== 1'b0) begin
            bad++;
            $display("[TB] FAIL warmup_cycle0: got act=%b want 0", ro_activate);
        end
        @(negedge clk);
        total++;
        if ({ro_activate, busy} !== 2'b11) begin
            bad++;
            $display("[TB] FAIL warmup_cycle1: got act=%b busy=%b want 1 1", ro_activate, busy);
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            total++;
            if ({ro_activate, busy, rnd_valid} !== 3'b110) begin
                bad++;
                $display("[TB] FAIL warmup_hold %0d: got act=%b busy=%b valid=%b want 1 1 0",
                         i, ro_activate, busy, rnd_valid);
            end
        end
        enable = 1'b0;
        @(negedge clk);
        total++;
        if ({ro_activate, busy} !== 2'b00) begin
            bad++;
            $display("[TB] FAIL warmup_abort: got act=%b busy=%b want 0 0", ro_activate, busy);
        end
    endtask

    task automatic test_debias_pack();
        // Pairs 10,01,11,10,00,01,01,10,01,10 -> bits 1,0,1,0,0,1,0,1 = 0xA5
        logic [19:0] pat;
        pat = 20'b10_01_11_10_00_01_01_10_01_10;
        do_reset();
        rnd_ready = 1'b1;
        start_run();
        validHigh = 0;
        for (int i = 19; i >= 0; i--) drive_sample(pat[i]);
        total++;
        if ({rnd_valid, rnd_byte} !== {1'b1, 8'hA5}) begin
            bad++;
            $display("[TB] FAIL debias_byte: got valid=%b byte=%h want 1 a5", rnd_valid, rnd_byte);
        end
        @(negedge clk);
        if (rnd_valid === 1'b1) validHigh++;
        total++;
        if (rnd_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL debias_consumed: got valid=%b want 0", rnd_valid);
        end
        total++;
        if (validHigh != 1) begin
            bad++;
            $display("[TB] FAIL debias_valid_cycles: got %0d want 1", validHigh);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        rnd_ready = 1'b0;
        start_run();
        drive_byte(8'h3C);
        total++;
        if ({rnd_valid, rnd_byte} !== {1'b1, 8'h3C}) begin
            bad++;
            $display("[TB] FAIL bp_first: got valid=%b byte=%h want 1 3c", rnd_valid, rnd_byte);
        end
        drive_byte(8'hC3);
        total++;
        if ({rnd_valid, rnd_byte, busy, ro_activate} !== {1'b1, 8'h3C, 1'b1, 1'b1}) begin
            bad++;
            $display("[TB] FAIL bp_stall: got valid=%b byte=%h busy=%b act=%b want 1 3c 1 1",
                     rnd_valid, rnd_byte, busy, ro_activate);
        end
        // A stuck-high oscillator would trip the health test if sampling continued while stalled.
        ro_in = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            total++;
            if ({rnd_valid, rnd_byte} !== {1'b1, 8'h3C}) begin
                bad++;
                $display("[TB] FAIL bp_hold %0d: got valid=%b byte=%h want 1 3c", i, rnd_valid, rnd_byte);
            end
        end
        total++;
        if (health_fail !== 1'b0) begin
            bad++;
            $display("[TB] FAIL bp_no_sampling: got hf=%b want 0", health_fail);
        end
        rnd_ready = 1'b1;
        @(negedge clk);
        total++;
        if ({rnd_valid, rnd_byte} !== {1'b1, 8'hC3}) begin
            bad++;
            $display("[TB] FAIL bp_second: got valid=%b byte=%h want 1 c3", rnd_valid, rnd_byte);
        end
        validHigh = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rnd_valid === 1'b1) validHigh++;
        end
        total++;
        if (validHigh != 0) begin
            bad++;
            $display("[TB] FAIL bp_no_duplicate: got %0d valid cycles want 0", validHigh);
        end
    endtask

    task automatic test_health_fail();
        do_reset();
        rnd_ready = 1'b1;
        start_run();
        validHigh = 0;
        for (int i = 0; i < 15; i++) drive_sample(1'b1);
        total++;
        if ({health_fail, ro_activate} !== 2'b01) begin
            bad++;
            $display("[TB] FAIL health_before: got hf=%b act=%b want 0 1", health_fail, ro_activate);
        end
        drive_sample(1'b1);
        total++;
        if ({health_fail, ro_activate, busy} !== 3'b100) begin
            bad++;
            $display("[TB] FAIL health_trip: got hf=%b act=%b busy=%b want 1 0 0", health_fail, ro_activate, busy);
        end
        total++;
        if (validHigh != 0) begin
            bad++;
            $display("[TB] FAIL health_no_byte: got %0d valid cycles want 0", validHigh);
        end
        enable = 1'b0;
        repeat (3) @(negedge clk);
        enable = 1'b1;
        repeat (20) @(negedge clk);
        total++;
        if ({health_fail, ro_activate, busy} !== 3'b100) begin
            bad++;
            $display("[TB] FAIL health_sticky: got hf=%b act=%b busy=%b want 1 0 0", health_fail, ro_activate, busy);
        end
        enable = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (health_fail !== 1'b0) begin
            bad++;
            $display("[TB] FAIL health_async_clear: got hf=%b want 0", health_fail);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_enable_drop();
        do_reset();
        rnd_ready = 1'b0;
        start_run();
        drive_byte(8'h5A);
        total++;
        if ({rnd_valid, rnd_byte} !== {1'b1, 8'h5A}) begin
            bad++;
            $display("[TB] FAIL drop_pending: got valid=%b byte=%h want 1 5a", rnd_valid, rnd_byte);
        end
        for (int i = 0; i < 5; i++) drive_pair(1'b1, 1'b0);
        enable = 1'b0;
        @(negedge clk);
        total++;
        if ({ro_activate, busy, rnd_valid, rnd_byte} !== {1'b0, 1'b0, 1'b1, 8'h5A}) begin
            bad++;
            $display("[TB] FAIL drop_idle: got act=%b busy=%b valid=%b byte=%h want 0 0 1 5a",
                     ro_activate, busy, rnd_valid, rnd_byte);
        end
        @(negedge clk);
        rnd_ready = 1'b1;
        @(negedge clk);
        total++;
        if (rnd_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL drop_delivered: got valid=%b want 0", rnd_valid);
        end
        validHigh = 0;
        start_run();
        drive_byte(8'h96);
        total++;
        if ({rnd_valid, rnd_byte} !== {1'b1, 8'h96}) begin
            bad++;
            $display("[TB] FAIL drop_fresh_byte: got valid=%b byte=%h want 1 96", rnd_valid, rnd_byte);
        end
        total++;
        if (validHigh != 1) begin
            bad++;
            $display("[TB] FAIL drop_byte_count: got %0d valid cycles want 1", validHigh);
        end
    endtask

    initial begin
        $display("[TB] starting trng_sampler directed tests");
        test_reset();
        test_warmup();
        test_debias_pack();
        test_back_to_back();
        test_health_fail();
        test_enable_drop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
